muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_signfix.sv | 78 +++++++
 rtl/muldiv_seq.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the sequential multiply/divide unit: operation
// encodings, FSM state type and small operation-decode helpers.
// Used by muldiv_signfix and muldiv_seq.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_t;

   // Divide operations have op[1] set.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   // Signed operations have op[0] clear.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix
// Combinational sign handling for muldiv_seq.
//   Operand side: op, a, b           -> a_mag, b_mag, a_neg, b_neg
//                 (signs only reported for signed operations)
//   Result side:  res_op, res_a_neg, res_b_neg, raw_hi, raw_lo
//                                    -> fix_hi, fix_lo
//   Multiply: the whole 2*WIDTH product is negated when the operand signs
//   differ. Divide: quotient negated when signs differ, remainder takes the
//   sign of the dividend.
module muldiv_signfix
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] a_mag,
   output logic [WIDTH-1:0] b_mag,
   output logic             a_neg,
   output logic             b_neg,
   input  logic [1:0]       res_op,
   input  logic             res_a_neg,
   input  logic             res_b_neg,
   input  logic [WIDTH-1:0] raw_hi,
   input  logic [WIDTH-1:0] raw_lo,
   output logic [WIDTH-1:0] fix_hi,
   output logic [WIDTH-1:0] fix_lo
);

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_neg;

   // Operand magnitudes; unsigned operations pass through untouched.
   always_comb begin
      a_neg = op_is_signed(op) & a[WIDTH-1];
      b_neg = op_is_signed(op) & b[WIDTH-1];
      if (a_neg) begin
         a_mag = {WIDTH{1'b0}} - a;
      end else begin
         a_mag = a;
      end
      if (b_neg) begin
         b_mag = {WIDTH{1'b0}} - b;
      end else begin
         b_mag = b;
      end
   end

   // Result sign correction.
   always_comb begin
      prod     = {raw_hi, raw_lo};
      prod_neg = {(2*WIDTH){1'b0}} - prod;
      fix_hi   = raw_hi;
      fix_lo   = raw_lo;
      if (op_is_div(res_op)) begin
         if (res_a_neg ^ res_b_neg) begin
            fix_lo = {WIDTH{1'b0}} - raw_lo;
         end else begin
            fix_lo = raw_lo;
         end
         if (res_a_neg) begin
            fix_hi = {WIDTH{1'b0}} - raw_hi;
         end else begin
            fix_hi = raw_hi;
         end
      end else begin
         if (res_a_neg ^ res_b_neg) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
         end else begin
            fix_hi = raw_hi;
            fix_lo = raw_lo;
         end
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Sequential 32-bit (parameter WIDTH) multiply / divide unit.
//   clock, reset (synchronous, active high)
//   start, op[1:0], a, b   : request, sampled only when idle
//   busy                   : operation in flight
//   done                   : one-cycle pulse when hi/lo/div0 update
//   hi, lo                 : product halves, or remainder / quotient
//   div0                   : divide-by-zero flag, valid with done
// One shift-add / restoring shift-subtract step per RUN cycle on operand
// magnitudes; signs are restored in FIX. A request is answered WIDTH+1
// cycles after it is accepted.
// Optional feature macro MULDIV_DIVZERO_EN: a divide by zero skips RUN,
// completes one cycle after acceptance and raises div0. Without it the
// divide runs full length and div0 stays 0. In both builds a zero divisor
// yields hi = a, lo = all ones.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH);

   state_t state;
   state_t next_state;

   logic [1:0]       sav_op;
   logic [WIDTH-1:0] sav_a;
   logic             sav_a_neg;
   logic             sav_b_neg;
   logic             sav_b_zero;
   logic [WIDTH-1:0] mcand;   // multiplicand / divisor magnitude
   logic [WIDTH-1:0] acc;     // product high half / partial remainder
   logic [WIDTH-1:0] mq;      // multiplier -> product low / dividend -> quotient
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] mq_step;
   logic             unused_top;

   muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
      .op        (op),
      .a         (a),
      .b         (b),
      .a_mag     (a_mag),
      .b_mag     (b_mag),
      .a_neg     (a_neg),
      .b_neg     (b_neg),
      .res_op    (sav_op),
      .res_a_neg (sav_a_neg),
      .res_b_neg (sav_b_neg),
      .raw_hi    (acc),
      .raw_lo    (mq),
      .fix_hi    (fix_hi),
      .fix_lo    (fix_lo)
   );

   assign busy = (state != IDLE);

   // One iteration of shift-add (multiply) or restoring shift-subtract (divide).
   always_comb begin
      sum     = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      shifted = {acc, mq[WIDTH-1]};
      diff    = shifted - {1'b0, mcand};
      fits    = (shifted >= {1'b0, mcand});
      if (op_is_div(sav_op)) begin
         // Partial remainder stays below the divisor, so WIDTH bits suffice.
         if (fits) begin
            acc_step = diff[WIDTH-1:0];
            mq_step  = {mq[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = shifted[WIDTH-1:0];
            mq_step  = {mq[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step = sum[WIDTH:1];
         mq_step  = {sum[0], mq[WIDTH-1:1]};
      end
   end

   assign unused_top = diff[WIDTH];

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef MULDIV_DIVZERO_EN
               if (op_is_div(op) && (b == {WIDTH{1'b0}})) begin
                  next_state = FIX;
               end else begin
                  next_state = RUN;
               end
`else
               next_state = RUN;
`endif
            end else begin
               next_state = IDLE;
            end
         end
         RUN: begin
            if (count == CW'(WIDTH - 1)) begin
               next_state = FIX;
            end else begin
               next_state = RUN;
            end
         end
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operand capture, iteration datapath and registered results.
   always_ff @(posedge clock) begin
      if (reset) begin
         sav_op     <= OP_MULT;
         sav_a      <= {WIDTH{1'b0}};
         sav_a_neg  <= 1'b0;
         sav_b_neg  <= 1'b0;
         sav_b_zero <= 1'b0;
         mcand      <= {WIDTH{1'b0}};
         acc        <= {WIDTH{1'b0}};
         mq         <= {WIDTH{1'b0}};
         count      <= {CW{1'b0}};
         hi         <= {WIDTH{1'b0}};
         lo         <= {WIDTH{1'b0}};
         done       <= 1'b0;
         div0       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sav_op     <= op;
                  sav_a      <= a;
                  sav_a_neg  <= a_neg;
                  sav_b_neg  <= b_neg;
                  sav_b_zero <= (b == {WIDTH{1'b0}});
                  mcand      <= b_mag;
                  acc        <= {WIDTH{1'b0}};
                  mq         <= a_mag;
                  count      <= {CW{1'b0}};
               end else begin
                  count      <= count;
               end
            end
            RUN: begin
               done  <= 1'b0;
               acc   <= acc_step;
               mq    <= mq_step;
               count <= count + CW'(1);
            end
            FIX: begin
               done <= 1'b1;
               if (op_is_div(sav_op) && sav_b_zero) begin
                  hi <= sav_a;
                  lo <= {WIDTH{1'b1}};
               end else begin
                  hi <= fix_hi;
                  lo <= fix_lo;
               end
`ifdef MULDIV_DIVZERO_EN
               div0 <= op_is_div(sav_op) & sav_b_zero;
`else
               div0 <= 1'b0;
`endif
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
// Directed self-checking bench for muldiv_seq (WIDTH=32). Latency is counted
// in rising edges after the edge that accepts start.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div0;

   int checks   = 0;
   int failures = 0;
   int lat;
   int cnt;
   logic [31:0] keep_hi;
   logic [31:0] keep_lo;

   muldiv_seq #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .div0  (div0)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request; returns #1 after the accepting edge.
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Edges until done is seen; 999 on timeout.
   task automatic wait_done(output int n);
      n = 999;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clock);
         #1;
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = OP_MULT;
      a     = 32'd0;
      b     = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hi",   {32'd0, hi},   64'd0);
      check("rst_lo",   {32'd0, lo},   64'd0);
      check("rst_div0", {63'd0, div0}, 64'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // MULT -3 * 5
      launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      check("mult_busy", {63'd0, busy}, 64'd1);
      wait_done(lat);
      check("mult_lat",  64'(lat), 64'd33);
      check("mult_hi",   {32'd0, hi}, 64'hFFFF_FFFF);
      check("mult_lo",   {32'd0, lo}, 64'hFFFF_FFF1);
      check("mult_div0", {63'd0, div0}, 64'd0);
      @(posedge clock);
      #1;
      check("done_pulse", {63'd0, done}, 64'd0);
      check("idle_busy",  {63'd0, busy}, 64'd0);

      // MULTU of the same bit patterns
      launch(OP_MULTU, 32'hFFFF_FFFD, 32'd5);
      wait_done(lat);
      check("multu_hi", {32'd0, hi}, 64'h0000_0004);
      check("multu_lo", {32'd0, lo}, 64'hFFFF_FFF1);

      // DIVU 100/7, then back-to-back MULTU on the done cycle
      launch(OP_DIVU, 32'd100, 32'd7);
      wait_done(lat);
      check("divu_lat", 64'(lat), 64'd33);
      check("divu_lo",  {32'd0, lo}, 64'd14);
      check("divu_hi",  {32'd0, hi}, 64'd2);
      launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat);
      check("b2b_lat", 64'(lat), 64'd33);
      check("b2b_hi",  {32'd0, hi}, 64'hFFFF_FFFE);
      check("b2b_lo",  {32'd0, lo}, 64'h0000_0001);

      // Signed divides
      launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat);
      check("div_m7_lo", {32'd0, lo}, 64'hFFFF_FFFD);
      check("div_m7_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);
      wait_done(lat);
      check("div_7m2_lo", {32'd0, lo}, 64'hFFFF_FFFD);
      check("div_7m2_hi", {32'd0, hi}, 64'd1);
      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat);
      check("div_wrap_lo",   {32'd0, lo}, 64'h8000_0000);
      check("div_wrap_hi",   {32'd0, hi}, 64'd0);
      check("div_wrap_div0", {63'd0, div0}, 64'd0);

      // Divide by zero
      launch(OP_DIVU, 32'd5, 32'd0);
      wait_done(lat);
`ifdef MULDIV_DIVZERO_EN
      check("dz_lat",  64'(lat), 64'd1);
      check("dz_div0", {63'd0, div0}, 64'd1);
`else
      check("dz_lat",  64'(lat), 64'd33);
      check("dz_div0", {63'd0, div0}, 64'd0);
`endif
      check("dz_hi", {32'd0, hi}, 64'd5);
      check("dz_lo", {32'd0, lo}, 64'hFFFF_FFFF);

      // Results hold between done pulses
      keep_hi = hi;
      keep_lo = lo;
      repeat (5) @(posedge clock);
      #1;
      check("hold_hi", {32'd0, hi}, {32'd0, keep_hi});
      check("hold_lo", {32'd0, lo}, {32'd0, keep_lo});

      // Start while busy is ignored: 6*7 with a 9*9 pulse mid-flight
      launch(OP_MULT, 32'd6, 32'd7);
      repeat (5) @(posedge clock);
      #1;
      start = 1'b1;
      op    = OP_MULTU;
      a     = 32'd9;
      b     = 32'd9;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("ign_busy", {63'd0, busy}, 64'd1);
      wait_done(lat);
      check("ign_lat", 64'(lat), 64'd27);
      check("ign_hi",  {32'd0, hi}, 64'd0);
      check("ign_lo",  {32'd0, lo}, 64'd42);

      // Reset mid-operation, with start coincident with reset
      launch(OP_MULT, 32'd3, 32'd4);
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      start = 1'b1;
      op    = OP_MULT;
      a     = 32'd11;
      b     = 32'd13;
      @(posedge clock);
      #1;
      reset = 1'b0;
      start = 1'b0;
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_done", {63'd0, done}, 64'd0);
      check("mid_rst_hi",   {32'd0, hi},   64'd0);
      check("mid_rst_lo",   {32'd0, lo},   64'd0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (done || busy) cnt++;
      end
      check("mid_rst_quiet", 64'(cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
